// File: rtl/video_timing_pkg.sv
// ============================================================================
// Module   : video_timing_pkg
// Purpose  : PAL 48K raster defaults shared by the timing source and scandoubler
// Revision : 1.0
// ============================================================================
`default_nettype none

package video_timing_pkg;

    localparam int PAL_HTOTAL       = 448;
    localparam int PAL_VTOTAL       = 312;
    localparam int PAL_HBLANK_START = 320;
    localparam int PAL_HBLANK_END   = 416;
    localparam int PAL_HSYNC_START  = 344;
    localparam int PAL_HSYNC_LEN    = 32;
    localparam int PAL_VBLANK_START = 248;
    localparam int PAL_VBLANK_END   = 256;
    localparam int PAL_VSYNC_START  = 248;
    localparam int PAL_VSYNC_LINES  = 4;

    localparam int RGB_W   = 9;
    localparam int CNT_W   = 9;
    localparam int CMP_W   = 10;

    // Length of a half-open [start, stop) window on a ring of 'total' positions.
    function automatic logic [CMP_W-1:0] win_len(input int start, input int stop, input int total);
        if (stop >= start)
            return CMP_W'(stop - start);
        else
            return CMP_W'(stop + total - start);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_window_cmp.sv
// ============================================================================
// Module   : sync_window_cmp
// Purpose  : membership test pos in [start, start+len) modulo total
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_window_cmp
    import video_timing_pkg::*;
(
    input  logic [CMP_W-1:0] pos_i,
    input  logic [CMP_W-1:0] start_i,
    input  logic [CMP_W-1:0] len_i,
    input  logic [CMP_W-1:0] total_i,
    output logic             in_o
);

    logic [CMP_W:0] w_dist;

    // Distance from start going forward around the ring; one extra bit holds pos+total.
    always_comb begin
        if (pos_i >= start_i)
            w_dist = {1'b0, pos_i} - {1'b0, start_i};
        else
            w_dist = {1'b0, pos_i} + {1'b0, total_i} - {1'b0, start_i};
        in_o = (w_dist < {1'b0, len_i});
    end

endmodule

`default_nettype wire

// File: rtl/video_timing_gen15k.sv
// ============================================================================
// Module   : video_timing_gen15k
// Purpose  : 15 kHz raster counters, sync generation and blanked RGB output
// Revision : 1.0
// ============================================================================
`default_nettype none

module video_timing_gen15k
    import video_timing_pkg::*;
#(
    parameter int HTOTAL       = PAL_HTOTAL,
    parameter int VTOTAL       = PAL_VTOTAL,
    parameter int HBLANK_START = PAL_HBLANK_START,
    parameter int HBLANK_END   = PAL_HBLANK_END,
    parameter int HSYNC_START  = PAL_HSYNC_START,
    parameter int HSYNC_LEN    = PAL_HSYNC_LEN,
    parameter int VBLANK_START = PAL_VBLANK_START,
    parameter int VBLANK_END   = PAL_VBLANK_END,
    parameter int VSYNC_START  = PAL_VSYNC_START,
    parameter int VSYNC_LINES  = PAL_VSYNC_LINES
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             pixen,
    input  logic             csync_mode,
    input  logic [RGB_W-1:0] rgb_in,
    output logic [CNT_W-1:0] hc,
    output logic [CNT_W-1:0] vc,
    output logic             line_start,
    output logic             frame_start,
    output logic [2:0]       ro,
    output logic [2:0]       go,
    output logic [2:0]       bo,
    output logic             hsync_n,
    output logic             vsync_n,
    output logic             csync_n,
    output logic             blank
);

    localparam logic [CNT_W-1:0] C_HLAST    = CNT_W'(HTOTAL - 1);
    localparam logic [CNT_W-1:0] C_VLAST    = CNT_W'(VTOTAL - 1);
    localparam logic [CNT_W-1:0] C_HHALF    = CNT_W'(HTOTAL / 2);
    localparam logic [CNT_W-1:0] C_SERR_LEN = CNT_W'(HTOTAL / 2 - HSYNC_LEN);
    localparam logic [CMP_W-1:0] C_HTOT     = CMP_W'(HTOTAL);
    localparam logic [CMP_W-1:0] C_VTOT     = CMP_W'(VTOTAL);
    localparam logic [CMP_W-1:0] C_HBL_LEN  = win_len(HBLANK_START, HBLANK_END, HTOTAL);
    localparam logic [CMP_W-1:0] C_VBL_LEN  = win_len(VBLANK_START, VBLANK_END, VTOTAL);

    logic [CNT_W-1:0] hc_q, hc_d, vc_q, vc_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic             blank_q, blank_d, hsync_q, hsync_d, vsync_q, vsync_d, csync_q, csync_d;
    logic             line_q, line_d, frame_q, frame_d;

    logic             w_hblank, w_vblank, w_hs, w_vs, w_serr;
    logic [CNT_W-1:0] w_hphase;

    sync_window_cmp u_hblank (.pos_i({1'b0, hc_q}), .start_i(CMP_W'(HBLANK_START)),
                              .len_i(C_HBL_LEN), .total_i(C_HTOT), .in_o(w_hblank));
    sync_window_cmp u_vblank (.pos_i({1'b0, vc_q}), .start_i(CMP_W'(VBLANK_START)),
                              .len_i(C_VBL_LEN), .total_i(C_VTOT), .in_o(w_vblank));
    sync_window_cmp u_hs     (.pos_i({1'b0, hc_q}), .start_i(CMP_W'(HSYNC_START)),
                              .len_i(CMP_W'(HSYNC_LEN)), .total_i(C_HTOT), .in_o(w_hs));
    sync_window_cmp u_vs     (.pos_i({1'b0, vc_q}), .start_i(CMP_W'(VSYNC_START)),
                              .len_i(CMP_W'(VSYNC_LINES)), .total_i(C_VTOT), .in_o(w_vs));

    // Serrated vsync: broad pulse at the start of each half line.
    assign w_hphase = (hc_q >= C_HHALF) ? (hc_q - C_HHALF) : hc_q;
    assign w_serr   = (w_hphase < C_SERR_LEN);

    always_comb begin
        hc_d    = hc_q;
        vc_d    = vc_q;
        rgb_d   = rgb_q;
        blank_d = blank_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        csync_d = csync_q;
        line_d  = pixen && (hc_q == '0);
        frame_d = pixen && (hc_q == '0) && (vc_q == '0);
        if (pixen) begin
            if (hc_q == C_HLAST) begin
                hc_d = '0;
                vc_d = (vc_q == C_VLAST) ? '0 : vc_q + 1'b1;
            end else begin
                hc_d = hc_q + 1'b1;
            end
            blank_d = w_hblank | w_vblank;
            rgb_d   = (w_hblank | w_vblank) ? '0 : rgb_in;
            hsync_d = ~w_hs;
            vsync_d = ~w_vs;
            if (csync_mode)
                csync_d = w_vs ? ~w_serr : ~w_hs;
            else
                csync_d = ~(w_hs ^ w_vs);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hc_q    <= '0;
            vc_q    <= '0;
            rgb_q   <= '0;
            blank_q <= 1'b1;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            csync_q <= 1'b1;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            rgb_q   <= rgb_d;
            blank_q <= blank_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            csync_q <= csync_d;
            line_q  <= line_d;
            frame_q <= frame_d;
        end
    end

    assign hc          = hc_q;
    assign vc          = vc_q;
    assign ro          = rgb_q[8:6];
    assign go          = rgb_q[5:3];
    assign bo          = rgb_q[2:0];
    assign blank       = blank_q;
    assign hsync_n     = hsync_q;
    assign vsync_n     = vsync_q;
    assign csync_n     = csync_q;
    assign line_start  = line_q;
    assign frame_start = frame_q;

endmodule

`default_nettype wire
